// File: rtl/uart_tx_arb_pkg.sv
// Shared types and defaults for the uart_tx arbiter slice.
package uart_tx_arb_pkg;

   // Encodings kept identical to the legacy localparam values.
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LAUNCH    = 2'd1,
      ST_WAIT_DONE = 2'd2,
      ST_GAP       = 2'd3
   } arb_state_e;

   localparam int unsigned DEF_GAP_CLKS     = 87;
   localparam int unsigned DEF_TIMEOUT_CLKS = 1024;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/uart_tx_arb_pick.sv
// One-hot round-robin picker: first valid requester at or after i_Ptr (wrapping).
// A pointer tied to 0 turns this into a fixed lowest-index-wins priority picker.
module uart_tx_arb_pick
   import uart_tx_arb_pkg::*;
#(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned PW    = 1
) (
   input  logic [N_REQ-1:0] i_Valid,
   input  logic [PW-1:0]    i_Ptr,
   output logic [N_REQ-1:0] o_Grant,
   output logic [PW-1:0]    o_Idx
);

   logic        found;
   int unsigned cand;

   // Walk the requesters starting at the pointer; the first valid one wins.
   always_comb begin
      o_Grant = '0;
      o_Idx   = '0;
      found   = 1'b0;
      cand    = 0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         cand = (32'(i_Ptr) + k) % N_REQ;
         if (!found && i_Valid[cand]) begin
            found         = 1'b1;
            o_Grant[cand] = 1'b1;
            o_Idx         = PW'(cand);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer between N_REQ byte sources.
// Round-robin by default; define UART_TX_ARB_FIXED_PRIO_EN for fixed
// lowest-index priority (pointer held at 0). Aborts a frame whose
// serializer never reports done within TIMEOUT_CLKS clocks.
module uart_tx_arbiter
   import uart_tx_arb_pkg::*;
#(
   parameter int unsigned N_REQ        = 2,
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned GAP_CLKS     = DEF_GAP_CLKS,
   parameter int unsigned TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
   input  logic                    i_Clock,
   input  logic                    i_Rst_n,
   input  logic [N_REQ-1:0]        i_Req_Valid,
   input  logic [N_REQ*DATA_W-1:0] i_Req_Byte,
   output logic [N_REQ-1:0]        o_Req_Ready,
   output logic                    o_Tx_DV,
   output logic [DATA_W-1:0]       o_Tx_Byte,
   input  logic                    i_Tx_Done,
   output logic [N_REQ-1:0]        o_Grant,
   output logic                    o_Busy,
   output logic                    o_Timeout
);

   localparam int unsigned PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned CNT_W = $clog2(max_u(GAP_CLKS, TIMEOUT_CLKS) + 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CLKS - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CLKS == 0) ? 0 : GAP_CLKS - 1);

   arb_state_e       state;
   logic [PW-1:0]    ptr;
   logic [PW-1:0]    ptr_nxt;
   logic [CNT_W-1:0] cnt;
   logic [N_REQ-1:0] pick_grant;
   logic [PW-1:0]    pick_idx;

   uart_tx_arb_pick #(
      .N_REQ (N_REQ),
      .PW    (PW)
   ) u_pick (
      .i_Valid (i_Req_Valid),
      .i_Ptr   (ptr),
      .o_Grant (pick_grant),
      .o_Idx   (pick_idx)
   );

`ifdef UART_TX_ARB_FIXED_PRIO_EN
   assign ptr_nxt = '0;
`else
   assign ptr_nxt = (pick_idx == PW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
`endif

   // Ready is gated by reset too, so an asserted reset shows no accept even though state decodes IDLE.
   assign o_Req_Ready = (state == ST_IDLE && i_Rst_n) ? pick_grant : '0;
   assign o_Tx_DV     = (state == ST_LAUNCH);
   assign o_Busy      = (state != ST_IDLE);

   // Frame sequencing: accept, launch, wait for done or timeout, then idle gap.
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state     <= ST_IDLE;
         ptr       <= '0;
         cnt       <= '0;
         o_Tx_Byte <= '0;
         o_Grant   <= '0;
         o_Timeout <= 1'b0;
      end else begin
         o_Timeout <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (|i_Req_Valid) begin
                  o_Tx_Byte <= i_Req_Byte[32'(pick_idx)*DATA_W +: DATA_W];
                  o_Grant   <= pick_grant;
                  ptr       <= ptr_nxt;
                  state     <= ST_LAUNCH;
               end
            end
            ST_LAUNCH: begin
               cnt   <= '0;
               state <= ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
               if (i_Tx_Done) begin
                  cnt   <= '0;
                  state <= ST_GAP;
               end else if (cnt == TO_LAST) begin
                  o_Timeout <= 1'b1;
                  cnt       <= '0;
                  state     <= ST_GAP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_GAP: begin
               if (GAP_CLKS == 0 || cnt == GAP_LAST) begin
                  cnt     <= '0;
                  o_Grant <= '0;
                  state   <= ST_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (N_REQ=2, GAP_CLKS=4, TIMEOUT_CLKS=32).
// A small uart_tx stand-in raises done a configurable number of clocks after each launch.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [15:0] req_byte;
   logic [1:0]  req_ready;
   logic        tx_dv;
   logic [7:0]  tx_byte;
   logic        tx_done;
   logic [1:0]  grant;
   logic        busy;
   logic        timeout;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int last_done_cyc = -100;
   int to_cnt   = 0;
   int dcnt     = 0;
   int done_dly = 20;
   bit done_en  = 1'b1;
   bit both_rdy = 1'b0;
   bit gap_busy_err = 1'b0;

   uart_tx_arbiter #(
      .N_REQ        (2),
      .DATA_W       (8),
      .GAP_CLKS     (4),
      .TIMEOUT_CLKS (32)
   ) dut (
      .i_Clock     (clk),
      .i_Rst_n     (rst_n),
      .i_Req_Valid (req_valid),
      .i_Req_Byte  (req_byte),
      .o_Req_Ready (req_ready),
      .o_Tx_DV     (tx_dv),
      .o_Tx_Byte   (tx_byte),
      .i_Tx_Done   (tx_done),
      .o_Grant     (grant),
      .o_Busy      (busy),
      .o_Timeout   (timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Serializer stand-in: done is high in the cycle done_dly clocks after the DV cycle.
   always @(posedge clk) begin
      if (!rst_n)                       dcnt <= 0;
      else if (tx_dv)                   dcnt <= 1;
      else if (dcnt != 0 && dcnt < 200) dcnt <= dcnt + 1;
   end
   assign tx_done = done_en && (dcnt == done_dly);

   // Background observations, checked later by the main sequence.
   always @(negedge clk) begin
      if (tx_done) last_done_cyc = cyc;
      if (req_ready == 2'b11) both_rdy = 1'b1;
      if (timeout) to_cnt = to_cnt + 1;
      if (rst_n && cyc > last_done_cyc && cyc <= last_done_cyc + 4 && !busy) gap_busy_err = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // which: 0 = DV pulse, 1 = timeout pulse, 2 = back in IDLE
   task automatic wait_for(input string tag, input int which, input int max_cyc);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < max_cyc && !ok; i++) begin
         @(negedge clk);
         case (which)
            0:       ok = tx_dv;
            1:       ok = timeout;
            default: ok = !busy;
         endcase
      end
      check(tag, 32'(ok), 32'd1);
   endtask

   logic [7:0] exp_b [4];
   logic [1:0] exp_g [4];
   int dv_c;
   int t0;

   initial begin
      rst_n = 1'b0; req_valid = '0; req_byte = '0;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
      exp_b = '{8'h11, 8'h11, 8'h11, 8'h11};
      exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
      exp_b = '{8'h11, 8'h22, 8'h11, 8'h22};
      exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
      repeat (3) @(negedge clk);
      check("rst_outs", 32'({busy, tx_dv, timeout, grant, tx_byte, req_ready}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single request
      req_byte[7:0] = 8'hA5; req_valid = 2'b01;
      #1 check("single_ready", 32'(req_ready), 32'h1);
      check("single_idle_dv", 32'(tx_dv), 32'h0);
      @(negedge clk);
      check("single_dv", 32'(tx_dv), 32'h1);
      check("single_byte", 32'(tx_byte), 32'hA5);
      check("single_grant", 32'(grant), 32'h1);
      check("launch_ready0", 32'(req_ready), 32'h0);
      check("launch_busy", 32'(busy), 32'h1);
      req_valid = 2'b00;
      @(negedge clk);
      check("dv_one_cycle", 32'(tx_dv), 32'h0);
      wait_for("single_idle", 2, 60);
      check("idle_grant0", 32'(grant), 32'h0);

      // Contention from a fresh pointer
      rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
      req_byte = {8'h22, 8'h11}; req_valid = 2'b11;
      for (int f = 0; f < 4; f++) begin
         wait_for("cont_dv_seen", 0, 80);
         if (f == 3) req_valid = 2'b00;
         check("cont_byte", 32'(tx_byte), 32'(exp_b[f]));
         check("cont_grant", 32'(grant), 32'(exp_g[f]));
         // done cycle t, GAP t+1..t+4, IDLE t+5, DV t+6
         if (f > 0) check("gap_spacing", 32'(cyc - last_done_cyc), 32'd6);
      end
      wait_for("cont_idle", 2, 60);
      check("ready_onehot", 32'(both_rdy), 32'd0);
      check("gap_busy", 32'(gap_busy_err), 32'd0);

      // Done in the last WAIT_DONE cycle beats the timeout
      done_dly = 32; t0 = to_cnt;
      req_byte[7:0] = 8'h3C; req_valid = 2'b01;
      wait_for("tie_dv_seen", 0, 20);
      req_valid = 2'b00;
      wait_for("tie_idle", 2, 80);
      check("tie_no_timeout", 32'(to_cnt - t0), 32'd0);

      // Stuck serializer
      done_dly = 20; done_en = 1'b0;
      req_byte = {8'hC3, 8'h5A}; req_valid = 2'b01;
      wait_for("to_dv_seen", 0, 20);
      dv_c = cyc;
      req_valid = 2'b10;
      wait_for("to_pulse_seen", 1, 60);
      // DV cycle, then 32 WAIT_DONE cycles, then the pulse
      check("to_latency", 32'(cyc - dv_c), 32'd33);
      check("to_busy", 32'(busy), 32'h1);
      @(negedge clk);
      check("to_pulse_width", 32'(timeout), 32'h0);
      done_en = 1'b1;
      wait_for("after_to_dv", 0, 20);
      check("after_to_byte", 32'(tx_byte), 32'hC3);
      check("after_to_grant", 32'(grant), 32'h2);
      req_valid = 2'b00;
      wait_for("after_to_idle", 2, 60);

      // Reset mid-WAIT_DONE with a request still held
      req_byte[7:0] = 8'h77; req_valid = 2'b01;
      wait_for("rst_dv_seen", 0, 20);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1 check("rst_mid_outs", 32'({busy, tx_dv, timeout, grant, tx_byte, req_ready}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("rst_rel_busy", 32'(busy), 32'h0);
      check("rst_rel_ready", 32'(req_ready), 32'h1);
      @(negedge clk);
      check("rst_rel_dv", 32'(tx_dv), 32'h1);
      check("rst_rel_byte", 32'(tx_byte), 32'h77);
      req_valid = 2'b00;
      wait_for("final_idle", 2, 60);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
